// File: rtl/vgg16_pkg.sv
// Shared FP32 field layout, signed-zero constants and pooling geometry for the VGG16 pipeline.
// Contents: fp32_t field struct, FP_POS_ZERO/FP_NEG_ZERO, POOL_SIZE, fp32_is_zero helper.
// No ports; imported by the pooling stage and its comparator.
package vgg16_pkg;

  localparam int FP_SIGN_W = 1;
  localparam int FP_EXP_W  = 8;
  localparam int FP_MAN_W  = 23;
  localparam int FP_WIDTH  = FP_SIGN_W + FP_EXP_W + FP_MAN_W;

  localparam logic [FP_WIDTH-1:0] FP_POS_ZERO = 32'h0000_0000;
  localparam logic [FP_WIDTH-1:0] FP_NEG_ZERO = 32'h8000_0000;

  // Pooling window edge and stride (square, non-overlapping).
  localparam int POOL_SIZE = 2;

  typedef struct packed {
    logic                sign;
    logic [FP_EXP_W-1:0] exp;
    logic [FP_MAN_W-1:0] man;
  } fp32_t;

  // True for both +0 and -0: clearing the sign bit must leave all-zero.
  function automatic logic fp32_is_zero(input fp32_t x);
    logic [FP_WIDTH-1:0] bits;
    bits = x;
    return (bits & ~FP_NEG_ZERO) == FP_POS_ZERO;
  endfunction

endpackage

// File: rtl/fp32_max2.sv
// Combinational FP32 maximum of two operands; the first operand wins ties and +0/-0 are equal.
// Ports: a, b (FP32 operands), y (selected operand, bit-exact copy of a or b).
// NaN/Inf get no special treatment: they order like any other sign-magnitude pattern.
module fp32_max2
  import vgg16_pkg::*;
(
  input  logic [FP_WIDTH-1:0] a,
  input  logic [FP_WIDTH-1:0] b,
  output logic [FP_WIDTH-1:0] y
);

  fp32_t fa;
  fp32_t fb;
  logic  b_greater;

  assign fa = a;
  assign fb = b;

  always_comb begin
    b_greater = 1'b0;
    if (fp32_is_zero(fa) && fp32_is_zero(fb)) begin
      // Signed zeros tie, so the first operand is kept.
      b_greater = 1'b0;
    end else if (fa.sign != fb.sign) begin
      b_greater = ~fb.sign;
    end else if (!fa.sign) begin
      b_greater = {fb.exp, fb.man} > {fa.exp, fa.man};
    end else begin
      // Both negative: the smaller magnitude is the larger value.
      b_greater = {fb.exp, fb.man} < {fa.exp, fa.man};
    end
    y = b_greater ? b : a;
  end

endmodule

// File: rtl/block1_pool_8_channel.sv
// Streaming 2x2 stride-2 FP32 max-pool over 8 parallel channels fed in raster order.
// Ports: clk, reset (sync, active-high), valid_in + data_in0..7 in; data_out0..7, valid_out, done out.
// One pixel per cycle when valid_in is high, no backpressure; pooled result 1 cycle after the odd/odd pixel.
module block1_pool_8_channel
  import vgg16_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int IMG_WIDTH  = 20,
  parameter int IMG_HEIGHT = 20
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] data_in0,
  input  logic [DATA_WIDTH-1:0] data_in1,
  input  logic [DATA_WIDTH-1:0] data_in2,
  input  logic [DATA_WIDTH-1:0] data_in3,
  input  logic [DATA_WIDTH-1:0] data_in4,
  input  logic [DATA_WIDTH-1:0] data_in5,
  input  logic [DATA_WIDTH-1:0] data_in6,
  input  logic [DATA_WIDTH-1:0] data_in7,
  output logic [DATA_WIDTH-1:0] data_out0,
  output logic [DATA_WIDTH-1:0] data_out1,
  output logic [DATA_WIDTH-1:0] data_out2,
  output logic [DATA_WIDTH-1:0] data_out3,
  output logic [DATA_WIDTH-1:0] data_out4,
  output logic [DATA_WIDTH-1:0] data_out5,
  output logic [DATA_WIDTH-1:0] data_out6,
  output logic [DATA_WIDTH-1:0] data_out7,
  output logic                  valid_out,
  output logic                  done
);

  localparam int NUM_CH = 8;
  localparam int HALF_W = IMG_WIDTH / POOL_SIZE;
  localparam int COL_W  = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int ROW_W  = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam int IDX_W  = (HALF_W     > 1) ? $clog2(HALF_W)     : 1;

  if (DATA_WIDTH != FP_WIDTH) begin : g_bad_data_width
    $error("block1_pool_8_channel: DATA_WIDTH must be 32 (FP32)");
  end
  if ((IMG_WIDTH < POOL_SIZE) || ((IMG_WIDTH % POOL_SIZE) != 0)) begin : g_bad_width
    $error("block1_pool_8_channel: IMG_WIDTH must be even and >= 2");
  end
  if ((IMG_HEIGHT < POOL_SIZE) || ((IMG_HEIGHT % POOL_SIZE) != 0)) begin : g_bad_height
    $error("block1_pool_8_channel: IMG_HEIGHT must be even and >= 2");
  end

  typedef logic [DATA_WIDTH-1:0] word_t;

  word_t din    [NUM_CH];
  word_t pair_q [NUM_CH];
  word_t hmax   [NUM_CH];
  word_t vmax   [NUM_CH];
  word_t dout_q [NUM_CH];
  // Top-row horizontal maxima waiting for their bottom-row partner.
  word_t lb     [NUM_CH][HALF_W];

  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic [IDX_W-1:0] lb_idx;
  logic             col_last;
  logic             row_last;
  logic             odd_col;
  logic             odd_row;
  logic             valid_q;
  logic             done_q;

  assign din[0] = data_in0;
  assign din[1] = data_in1;
  assign din[2] = data_in2;
  assign din[3] = data_in3;
  assign din[4] = data_in4;
  assign din[5] = data_in5;
  assign din[6] = data_in6;
  assign din[7] = data_in7;

  assign lb_idx   = IDX_W'(col >> 1);
  assign col_last = (col == COL_W'(IMG_WIDTH - 1));
  assign row_last = (row == ROW_W'(IMG_HEIGHT - 1));
  assign odd_col  = col[0];
  assign odd_row  = row[0];

  // Horizontal compare: pair register (left pixel) against the incoming right pixel.
  // Vertical compare: buffered top-row result against the bottom-row horizontal max.
  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    fp32_max2 u_hmax (
      .a (pair_q[ch]),
      .b (din[ch]),
      .y (hmax[ch])
    );
    fp32_max2 u_vmax (
      .a (lb[ch][lb_idx]),
      .b (hmax[ch]),
      .y (vmax[ch])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      col     <= '0;
      row     <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      for (int ch = 0; ch < NUM_CH; ch++) begin
        pair_q[ch] <= '0;
        dout_q[ch] <= '0;
      end
    end else begin
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      if (valid_in) begin
        if (!odd_col) begin
          for (int ch = 0; ch < NUM_CH; ch++) begin
            pair_q[ch] <= din[ch];
          end
        end else if (odd_row) begin
          for (int ch = 0; ch < NUM_CH; ch++) begin
            dout_q[ch] <= vmax[ch];
          end
          valid_q <= 1'b1;
          done_q  <= row_last && col_last;
        end
        // Row wraps after the frame's last pixel so frames can stream back-to-back.
        if (col_last) begin
          col <= '0;
          row <= row_last ? '0 : row + ROW_W'(1);
        end else begin
          col <= col + COL_W'(1);
        end
      end
    end
  end

  // Kept free of reset so it maps onto plain distributed RAM.
  always_ff @(posedge clk) begin
    if (!reset && valid_in && odd_col && !odd_row) begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        lb[ch][lb_idx] <= hmax[ch];
      end
    end
  end

  assign data_out0 = dout_q[0];
  assign data_out1 = dout_q[1];
  assign data_out2 = dout_q[2];
  assign data_out3 = dout_q[3];
  assign data_out4 = dout_q[4];
  assign data_out5 = dout_q[5];
  assign data_out6 = dout_q[6];
  assign data_out7 = dout_q[7];
  assign valid_out = valid_q;
  assign done      = done_q;

endmodule

// File: tb/tb_block1_pool_8_channel.sv
module tb_block1_pool_8_channel;

  localparam int SW = 4;
  localparam int SH = 4;
  localparam int LW = 20;
  localparam int LH = 20;

  localparam logic [31:0] FPN [16] = '{
    32'h00000000, 32'h3F800000, 32'h40000000, 32'h40400000,
    32'h40800000, 32'h40A00000, 32'h40C00000, 32'h40E00000,
    32'h41000000, 32'h41100000, 32'h41200000, 32'h41300000,
    32'h41400000, 32'h41500000, 32'h41600000, 32'h41700000};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // small (4x4) instance
  logic             s_reset, s_valid;
  logic [7:0][31:0] s_din;
  logic [7:0][31:0] s_dout;
  logic             s_vout, s_done;
  // large (20x20) instance
  logic             l_reset, l_valid;
  logic [7:0][31:0] l_din;
  logic [7:0][31:0] l_dout;
  logic             l_vout, l_done;

  block1_pool_8_channel #(.DATA_WIDTH(32), .IMG_WIDTH(SW), .IMG_HEIGHT(SH)) dut_s (
    .clk(clk), .reset(s_reset), .valid_in(s_valid),
    .data_in0(s_din[0]), .data_in1(s_din[1]), .data_in2(s_din[2]), .data_in3(s_din[3]),
    .data_in4(s_din[4]), .data_in5(s_din[5]), .data_in6(s_din[6]), .data_in7(s_din[7]),
    .data_out0(s_dout[0]), .data_out1(s_dout[1]), .data_out2(s_dout[2]), .data_out3(s_dout[3]),
    .data_out4(s_dout[4]), .data_out5(s_dout[5]), .data_out6(s_dout[6]), .data_out7(s_dout[7]),
    .valid_out(s_vout), .done(s_done));

  block1_pool_8_channel #(.DATA_WIDTH(32), .IMG_WIDTH(LW), .IMG_HEIGHT(LH)) dut_l (
    .clk(clk), .reset(l_reset), .valid_in(l_valid),
    .data_in0(l_din[0]), .data_in1(l_din[1]), .data_in2(l_din[2]), .data_in3(l_din[3]),
    .data_in4(l_din[4]), .data_in5(l_din[5]), .data_in6(l_din[6]), .data_in7(l_din[7]),
    .data_out0(l_dout[0]), .data_out1(l_dout[1]), .data_out2(l_dout[2]), .data_out3(l_dout[3]),
    .data_out4(l_dout[4]), .data_out5(l_dout[5]), .data_out6(l_dout[6]), .data_out7(l_dout[7]),
    .valid_out(l_vout), .done(l_done));

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int t5     = 0;
  bit cmp_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // FP max by value: both zeros tie, otherwise positive beats negative,
  // larger magnitude wins among positives, smaller among negatives; ties keep a.
  function automatic logic [31:0] fmax(input logic [31:0] a, input logic [31:0] b);
    if (a[30:0] == 31'd0 && b[30:0] == 31'd0) return a;
    if (a[31] != b[31]) return a[31] ? b : a;
    if (!a[31]) return (b[30:0] > a[30:0]) ? b : a;
    return (b[30:0] < a[30:0]) ? b : a;
  endfunction

  logic [31:0] mpix [2][8][LW*LH];
  int          mk   [2] = '{0, 0};
  logic        mvld [2] = '{1'b0, 1'b0};
  logic        mdone[2] = '{1'b0, 1'b0};
  logic [7:0][31:0] mdat [2];

  // The frame is stored whole; each 2x2 window is reduced as
  // max(max(top-left, top-right), max(bottom-left, bottom-right)).
  task automatic model_step(input int id, input int w, input int h, input logic rst,
                            input logic vld, input logic [7:0][31:0] d);
    int r, c;
    logic [31:0] tl, tr, bl;
    mvld[id]  = 1'b0;
    mdone[id] = 1'b0;
    if (rst) begin
      mk[id]   = 0;
      mdat[id] = '0;
    end else if (vld) begin
      r = mk[id] / w;
      c = mk[id] % w;
      for (int ch = 0; ch < 8; ch++) mpix[id][ch][mk[id]] = d[ch];
      if ((r % 2) == 1 && (c % 2) == 1) begin
        for (int ch = 0; ch < 8; ch++) begin
          tl = mpix[id][ch][mk[id] - w - 1];
          tr = mpix[id][ch][mk[id] - w];
          bl = mpix[id][ch][mk[id] - 1];
          mdat[id][ch] = fmax(fmax(tl, tr), fmax(bl, d[ch]));
        end
        mvld[id]  = 1'b1;
        mdone[id] = (mk[id] == w * h - 1);
      end
      mk[id] = (mk[id] + 1) % (w * h);
    end
  endtask

  always @(posedge clk) model_step(0, SW, SH, s_reset, s_valid, s_din);
  always @(posedge clk) model_step(1, LW, LH, l_reset, l_valid, l_din);

  // Cycle-by-cycle compare of both instances against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("s_valid_out", {255'd0, s_vout}, {255'd0, mvld[0]});
      chk("s_done",      {255'd0, s_done}, {255'd0, mdone[0]});
      chk("s_data_out",  s_dout, mdat[0]);
      chk("l_valid_out", {255'd0, l_vout}, {255'd0, mvld[1]});
      chk("l_done",      {255'd0, l_done}, {255'd0, mdone[1]});
      chk("l_data_out",  l_dout, mdat[1]);
    end
  end

  // Output capture for the literal expectations.
  logic [255:0] cap_d[$];
  bit           cap_done[$];
  int           cap_cyc[$];
  int           l_cnt = 0;
  int           l_done_cnt = 0;

  always @(negedge clk) begin
    if (s_vout === 1'b1) begin
      cap_d.push_back(s_dout);
      cap_done.push_back(s_done);
      cap_cyc.push_back(cyc);
    end
    if (l_vout === 1'b1) l_cnt++;
    if (l_done === 1'b1) l_done_cnt++;
  end

  // ---------------- stimulus ----------------
  logic [31:0] fr [8][16];

  task automatic s_idle(input int n);
    s_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input bit gaps);
    for (int k = 0; k < 16; k++) begin
      s_valid = 1'b1;
      for (int ch = 0; ch < 8; ch++) s_din[ch] = fr[ch][k];
      if (k == 5) t5 = cyc;
      @(negedge clk);
      if (gaps && (k == 2 || k == 7 || k == 13)) s_idle(3);
    end
    s_valid = 1'b0;
  endtask

  task automatic load_index_frame();
    for (int ch = 0; ch < 8; ch++)
      for (int k = 0; k < 16; k++) fr[ch][k] = FPN[k];
  endtask

  task automatic check_index_outputs(input string tag, input int base);
    logic [31:0] ev [4];
    ev = '{32'h40A00000, 32'h40E00000, 32'h41500000, 32'h41700000};
    chk({tag, "_count"}, 256'(cap_d.size() - base), 256'd4);
    if (cap_d.size() >= base + 4) begin
      for (int j = 0; j < 4; j++) begin
        chk({tag, "_value"}, cap_d[base + j], {8{ev[j]}});
        chk({tag, "_done"}, {255'd0, cap_done[base + j]}, {255'd0, (j == 3)});
      end
    end
  endtask

  function automatic logic [31:0] rnd_fp();
    logic [31:0] v;
    v[31]    = 1'($urandom_range(0, 1));
    v[30:23] = 8'($urandom_range(100, 150));
    v[22:0]  = 23'($urandom);
    return v;
  endfunction

  initial begin
    int base;
    s_reset = 1'b1; l_reset = 1'b1;
    s_valid = 1'b0; l_valid = 1'b0;
    s_din = '0; l_din = '0;
    repeat (2) @(negedge clk);
    chk("reset_valid_out", {255'd0, s_vout}, 256'd0);
    chk("reset_done", {255'd0, s_done}, 256'd0);
    chk("reset_data_out", s_dout, 256'd0);
    s_reset = 1'b0; l_reset = 1'b0;
    cmp_en = 1'b1;
    @(negedge clk);

    // 1: 4x4 raster-index frame, contiguous
    load_index_frame();
    base = cap_d.size();
    send_frame(1'b0);
    s_idle(3);
    check_index_outputs("idx", base);
    if (cap_d.size() > base) chk("first_latency", 256'(cap_cyc[base]), 256'(t5 + 1));

    // 2: negative window, then signed-zero window
    load_index_frame();
    for (int ch = 0; ch < 8; ch++) begin
      fr[ch][0] = 32'hC0000000; fr[ch][1] = 32'hBF800000;
      fr[ch][4] = 32'hC0400000; fr[ch][5] = 32'hC0800000;
    end
    base = cap_d.size();
    send_frame(1'b0);
    s_idle(2);
    if (cap_d.size() > base) chk("neg_window", cap_d[base], {8{32'hBF800000}});
    else chk("neg_window_present", 256'd0, 256'd1);
    for (int ch = 0; ch < 8; ch++) begin
      fr[ch][0] = 32'h80000000; fr[ch][1] = 32'h00000000;
      fr[ch][4] = 32'h80000000; fr[ch][5] = 32'h80000000;
    end
    base = cap_d.size();
    send_frame(1'b0);
    s_idle(2);
    if (cap_d.size() > base) chk("zero_window", cap_d[base], {8{32'h80000000}});
    else chk("zero_window_present", 256'd0, 256'd1);

    // 3: same index frame with valid_in gaps
    load_index_frame();
    base = cap_d.size();
    send_frame(1'b1);
    s_idle(3);
    check_index_outputs("gaps", base);

    // 4: reset mid-frame, valid_in held high during reset
    for (int k = 0; k < 9; k++) begin
      s_valid = 1'b1;
      for (int ch = 0; ch < 8; ch++) s_din[ch] = FPN[k];
      @(negedge clk);
    end
    s_reset = 1'b1;
    s_valid = 1'b1;
    for (int ch = 0; ch < 8; ch++) s_din[ch] = 32'h42C80000;
    @(negedge clk);
    chk("midreset_valid_out", {255'd0, s_vout}, 256'd0);
    chk("midreset_data_out", s_dout, 256'd0);
    s_reset = 1'b0;
    s_idle(1);
    chk("postreset_data_out", s_dout, 256'd0);
    chk("postreset_done", {255'd0, s_done}, 256'd0);
    base = cap_d.size();
    send_frame(1'b0);
    s_idle(3);
    check_index_outputs("after_reset", base);

    // 6: channel independence
    for (int ch = 0; ch < 8; ch++)
      for (int k = 0; k < 16; k++) fr[ch][k] = FPN[ch + 1];
    fr[3][5] = 32'h42C80000;
    base = cap_d.size();
    send_frame(1'b0);
    s_idle(3);
    chk("indep_count", 256'(cap_d.size() - base), 256'd4);
    if (cap_d.size() >= base + 4) begin
      for (int j = 0; j < 4; j++) begin
        for (int ch = 0; ch < 8; ch++) begin
          logic [255:0] v;
          v = cap_d[base + j];
          chk("indep_value", {224'd0, v[ch*32 +: 32]},
              {224'd0, (ch == 3 && j == 0) ? 32'h42C80000 : FPN[ch + 1]});
        end
      end
    end

    // 5: two back-to-back 20x20 random frames
    l_cnt = 0;
    l_done_cnt = 0;
    for (int k = 0; k < 2 * LW * LH; k++) begin
      l_valid = 1'b1;
      for (int ch = 0; ch < 8; ch++) l_din[ch] = rnd_fp();
      @(negedge clk);
    end
    l_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("large_output_count", 256'(l_cnt), 256'd200);
    chk("large_done_count", 256'(l_done_cnt), 256'd2);

    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/block1_pool_8_channel.md
Name: block1_pool_8_channel

Overview:
- Streaming 2x2 / stride-2 max-pooling stage for 8 parallel FP32 channels.
- Sits directly downstream of the block-1 8-kernel convolution. Consumes its raster-order output stream (data_out0..7 + valid_out) and produces the pooled feature map for block 2.
- No backpressure. One pixel per channel is accepted per cycle whenever valid_in is high.

Parameters:
- DATA_WIDTH, 32, word width; IEEE-754 single precision.
- IMG_WIDTH, 20, input columns; must be even and >=2, elaboration error otherwise.
- IMG_HEIGHT, 20, input rows; must be even and >=2, elaboration error otherwise.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- valid_in  input  1  data_in0..7 hold one valid pixel this cycle.
- data_in0..data_in7  input  DATA_WIDTH each  channel c pixel, raster order (row-major).
- data_out0..data_out7  output  DATA_WIDTH each  pooled pixel, channel c.
- valid_out  output  1  data_out0..7 valid this cycle.
- done  output  1  one-cycle pulse coincident with the last pooled pixel of a frame.

Behaviour:
- Reset: all outputs are 0; col/row counters are 0; line buffer contents are don't-care. Reset overrides valid_in in the same cycle. Reset mid-frame discards the partial frame, and the next accepted pixel is frame pixel (0,0).
- Counters: col 0..IMG_WIDTH-1 and row 0..IMG_HEIGHT-1 advance only on valid_in.
  - col wraps to 0 and increments row.
  - row wraps to 0 after the last pixel, so back-to-back frames need no idle cycle.
- valid_in low: counters, pair register and line buffer hold; valid_out=0; done=0.
- Even col: store pixel in pair register P[c].
- Odd col: horizontal max h = max(P[c], pixel).
  - Even row: write h into line buffer LB[c][col>>1]. Depth IMG_WIDTH/2 per channel.
  - Odd row: register max(LB[c][col>>1], h) into data_out c; valid_out=1 on the next cycle.
- Latency: 1 cycle from the accepting edge of an odd-row/odd-col pixel to valid_out high.
- Output count per frame: (IMG_WIDTH/2)*(IMG_HEIGHT/2). Example: 20x20 input gives 100 outputs.
- valid_out is 1 only on the odd-row/odd-col completions; otherwise 0.
- data_out holds its last value when valid_out=0.
- done=1 in the same cycle as valid_out for pooled pixel (H/2-1, W/2-1); 0 otherwise.
- FP max:
  - Total order on sign-magnitude: sign=1 values are ordered by inverted magnitude bits.
  - -0 and +0 compare equal; on a tie the first operand is returned (P or LB value).
  - NaN and Inf are not expected. They are compared as ordinary bit patterns, with no special handling.
  - Purely combinational, single level per cycle; no arithmetic, so the output is bit-exact with the inputs.
- All 8 channels share the counters and control; only the datapath is replicated.

Decomposition:
- Shared package (vgg16_pkg):
  - FP32 field widths: sign 1, exponent 8, mantissa 23.
  - FP_POS_ZERO = 32'h0000_0000 and FP_NEG_ZERO = 32'h8000_0000.
  - Pooling window/stride constant = 2.
- Sub-module fp32_max2 (combinational a,b -> max, tie returns a). Instantiated twice per channel: horizontal and vertical compares.
- Line buffer: plain reg array per channel, inferred as distributed RAM. No separate module.

Test Plan:
- Frame 4x4, all 8 channels = raster index as FP (0.0=0x00000000, 1.0=0x3F800000 … 15.0=0x41700000), valid_in held high -> exactly 4 valid_out pulses with values 5.0 (0x40A00000), 7.0 (0x40E00000), 13.0 (0x41500000), 15.0 (0x41700000); done high only with 15.0; first valid_out one cycle after pixel 5 is accepted.
- Negative window {-2.0 0xC0000000, -1.0 0xBF800000, -3.0 0xC0400000, -4.0 0xC0800000} -> -1.0 (0xBF800000). Window {-0, +0, -0, -0} -> 0x80000000 (tie keeps first operand).
- Same 4x4 frame with valid_in low for 3 cycles after pixels 2, 7 and 13 -> identical 4 output values and order; valid_out never asserted during gaps.
- Reset asserted for 1 cycle after 9 pixels of a 4x4 frame, then a full new frame -> only the 4 outputs of the new frame appear, with correct values; all outputs 0 during and right after reset.
- Two back-to-back 20x20 frames with per-channel distinct random data, compared against a golden model -> 100 outputs per frame, bit-exact; done pulses exactly twice.
- Channel independence: channel c fed constant (c+1).0, except channel 3 with one 100.0 at (row 1, col 1) -> channel 3 output (0,0)=100.0; every other output equals its channel constant.
